// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver with frame-synchronous
// shadow capture, per-digit blink and registered active-low outputs.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [31:0]        shadow_num;
  logic [7:0]         shadow_pt;
  logic [7:0]         shadow_le;

  logic       scan_wrap_c;
  logic       frame_end_c;
  logic       blink_wrap_c;
  logic [3:0] nibble_c;
  logic [7:0] an_nxt_c;
  logic [7:0] seg_nxt_c;

  // Active-low g..a pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan/blink wrap detection and next output values
  always_comb begin
    scan_wrap_c  = (scan_cnt == SCAN_LAST);
    frame_end_c  = scan_wrap_c && (digit == 3'd7);
    blink_wrap_c = (blink_cnt == BLINK_LAST);
    nibble_c     = shadow_num[{digit, 2'b00} +: 4];
    an_nxt_c     = 8'hFF;
    seg_nxt_c    = 8'hFF;
    if (EN) begin
      an_nxt_c = ~(8'b1 << digit);
      // Blinking digit keeps its anode driven but shows nothing in the off phase
      if (!(shadow_le[digit] && !blink_phase)) begin
        seg_nxt_c = {~shadow_pt[digit], hex_to_seg(nibble_c)};
      end
    end
  end

  // Digit scan counter and frame-boundary shadow capture
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt   <= '0;
      digit      <= 3'd0;
      shadow_num <= 32'h0;
      shadow_pt  <= 8'h00;
      shadow_le  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (scan_wrap_c) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (frame_end_c) begin
        shadow_num <= Disp_num;
        shadow_pt  <= point_in;
        shadow_le  <= LE;
      end
    end
  end

  // Free-running blink timer
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_wrap_c) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AN      <= 8'hFF;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= an_nxt_c;
      SEGMENT <= seg_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLINK_DIV=16:
// 4 cycles per digit, 32-cycle frames, blink phase flips every 16 cycles.
module tb_seg7_scan_driver;

  localparam int SCAN  = 4;
  localparam int FRAME = 8 * SCAN;

  logic        clk;
  logic        rst;
  logic        EN;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  LE;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [7:0] exp_tab [8];

  seg7_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .Disp_num   (Disp_num),
    .point_in   (point_in),
    .LE         (LE),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Reset-held cycle: everything blank, no frame pulse
  task automatic reset_tick();
    @(posedge clk);
    #1;
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEGMENT, 8'hFF);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
  endtask

  // Advance n cycles; output after edge k shows digit ((k-1)/SCAN)%8
  task automatic run(input int n);
    int d;
    logic [7:0] e_an, e_seg, e_fd;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      d     = ((cyc - 1) / SCAN) % 8;
      e_an  = EN ? ~(8'(1) << d) : 8'hFF;
      e_seg = EN ? exp_tab[d] : 8'hFF;
      e_fd  = (cyc % FRAME == 0) ? 8'h01 : 8'h00;
      chk("an", AN, e_an);
      chk("seg", SEGMENT, e_seg);
      chk("frame_done", {7'b0, frame_done}, e_fd);
    end
  endtask

  task automatic fill_tab(input logic [7:0] v);
    for (int i = 0; i < 8; i++) exp_tab[i] = v;
  endtask

  initial begin
    rst      = 1'b1;
    EN       = 1'b0;
    Disp_num = 32'h0;
    point_in = 8'h00;
    LE       = 8'h00;
    fill_tab(8'hC0);

    repeat (3) reset_tick();

    // First frame after reset shows zeros; new number is captured at its end
    rst      = 1'b0;
    EN       = 1'b1;
    Disp_num = 32'h89AB_CDEF;
    run(FRAME);

    exp_tab = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    run(12);
    // Mid-frame change at digit 3 must stay invisible until the next capture
    Disp_num = 32'h0;
    point_in = 8'h01;
    run(20);

    fill_tab(8'hC0);
    exp_tab[0] = 8'h40;
    run(16);
    Disp_num = 32'h1111_1111;
    point_in = 8'h00;
    LE       = 8'h22;
    run(16);

    // Digit 1 slot always falls in blink phase 1, digit 5 slot in phase 0
    fill_tab(8'hF9);
    exp_tab[5] = 8'hFF;
    run(FRAME);

    run(10);
    EN = 1'b0;
    run(6);
    EN = 1'b1;
    run(4);

    // Reset while digit 5 is selected
    rst = 1'b1;
    repeat (2) reset_tick();
    rst = 1'b0;
    cyc = 0;
    fill_tab(8'hC0);
    run(FRAME);
    fill_tab(8'hF9);
    exp_tab[5] = 8'hFF;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
